scanlines_ctrl: RTL and testbench

- Sequences the scanline mode code consumed by the scanlines datapath (scnl_sw[3:0]). Inputs are host register writes and a user "cycle" button.
- A new code is only applied at the start of a frame (rising edge of core_vs), so a frame is never split between two modes.
- The block monitors the core video timing. It forces the datapath to bypass (code 0) when video is absent or degenerate.
- Sits between the APF/interact register bridge and the scanlines module, in the clk_vid domain.

---
 rtl/scanlines_ctrl_if.sv | 28 ++
 rtl/scanlines_ctrl.sv | 164 ++++++++++++++++
 tb/tb_scanlines_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scanlines_ctrl_if.sv
// Signal bundle for scanlines_ctrl: host requests, core video timing in,
// datapath code and status out. The master side owns requests and timing.
interface scanlines_ctrl_if #(
    parameter int LC_W = 10
);
    logic [3:0]      cfg_sw;
    logic            cfg_wr;
    logic            btn_cycle;
    logic            core_hs;
    logic            core_vs;
    logic            core_de;
    logic [3:0]      scnl_sw;
    logic            pending;
    logic            applied;
    logic            cfg_err;
    logic            video_ok;
    logic [LC_W-1:0] line_count;

    modport master (
        output cfg_sw, cfg_wr, btn_cycle, core_hs, core_vs, core_de,
        input  scnl_sw, pending, applied, cfg_err, video_ok, line_count
    );

    modport slave (
        input  cfg_sw, cfg_wr, btn_cycle, core_hs, core_vs, core_de,
        output scnl_sw, pending, applied, cfg_err, video_ok, line_count
    );
endinterface

// File: rtl/scanlines_ctrl.sv
// Scanline mode sequencer: queues host/button mode requests and applies them
// only at a frame start, forcing bypass while core video is missing or too
// short to be a real frame.
module scanlines_ctrl #(
    parameter int WDOG_CYCLES = 2_000_000,
    parameter int MIN_LINES   = 16,
    parameter int LC_W        = 10
) (
    input logic             clk_vid,
    input logic             reset,
    scanlines_ctrl_if.slave bus
);
    localparam int              WD_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);
    localparam logic [LC_W-1:0] LC_MIN = LC_W'(MIN_LINES);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state, state_d;
    logic            vs_q, hs_q, btn_q;
    logic            vs_rise, hs_rise, btn_rise;
    logic [3:0]      active_sw, req_sw, req_code, scnl_q;
    logic            req_hit, pending_w, apply_now;
    logic            applied_q, cfg_err_q, video_ok;
    logic            de_seen;
    logic [LC_W-1:0] lcnt, line_count_q;
    logic [WD_W-1:0] wdog;

    function automatic logic code_valid(input logic [3:0] c);
        case (c)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd8, 4'd12, 4'd5, 4'd10, 4'd15: code_valid = 1'b1;
            default:                         code_valid = 1'b0;
        endcase
    endfunction

    // Cycle order 0,1,2,3,4,8,12,5,10,15 and back to 0.
    function automatic logic [3:0] code_next(input logic [3:0] c);
        case (c)
            4'd0:    code_next = 4'd1;
            4'd1:    code_next = 4'd2;
            4'd2:    code_next = 4'd3;
            4'd3:    code_next = 4'd4;
            4'd4:    code_next = 4'd8;
            4'd8:    code_next = 4'd12;
            4'd12:   code_next = 4'd5;
            4'd5:    code_next = 4'd10;
            4'd10:   code_next = 4'd15;
            default: code_next = 4'd0;
        endcase
    endfunction

    assign vs_rise  = bus.core_vs & ~vs_q;
    assign hs_rise  = bus.core_hs & ~hs_q;
    assign btn_rise = bus.btn_cycle & ~btn_q;

    // Previous-sample registers for the three edge detectors.
    always_ff @(posedge clk_vid or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            vs_q  <= 1'b0;
            hs_q  <= 1'b0;
            btn_q <= 1'b0;
        end else begin
            vs_q  <= bus.core_vs;
            hs_q  <= bus.core_hs;
            btn_q <= bus.btn_cycle;
        end
    end

    // Request selection: a host write always wins; a button edge steps from
    // the queued code if one is waiting, otherwise from the active code.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        req_hit  = 1'b0;
        req_code = req_sw;
        if (bus.cfg_wr) begin
            if (code_valid(bus.cfg_sw)) begin
                req_hit  = 1'b1;
                req_code = bus.cfg_sw;
            end
        end else if (btn_rise) begin
            req_hit  = 1'b1;
            req_code = code_next(pending_w ? req_sw : active_sw);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // FSM next state: stay in WAIT when a fresh request lands on the apply cycle.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (req_hit) state_d = S_WAIT;
            S_WAIT:  if (apply_now && !req_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: apply at a frame start, or at once when there is no video.
    always_comb begin
        pending_w = (state == S_WAIT);
        apply_now = pending_w && (vs_rise || !video_ok);
    end

    // Request capture, active code update, status pulses and output code.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            req_sw    <= 4'd0;
            active_sw <= 4'd0;
            applied_q <= 1'b0;
            cfg_err_q <= 1'b0;
            scnl_q    <= 4'd0;
        end else begin
            if (req_hit)   req_sw    <= req_code;
            if (apply_now) active_sw <= req_sw;
            applied_q <= apply_now;
            cfg_err_q <= bus.cfg_wr && !code_valid(bus.cfg_sw);
            scnl_q    <= video_ok ? active_sw : 4'd0;
        end
    end

    // Active line counter: a line counts if DE was seen before its hsync edge.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            de_seen      <= 1'b0;
            lcnt         <= '0;
            line_count_q <= '0;
        end else begin
            de_seen <= hs_rise ? 1'b0 : (de_seen | bus.core_de);
            if (vs_rise) begin
                line_count_q <= lcnt;
                lcnt         <= '0;
            end else if (hs_rise && (de_seen || bus.core_de) && (lcnt != '1)) begin
                lcnt <= lcnt + LC_W'(1);
            end
        end
    end

    // Watchdog on frame starts and the registered video-valid flag.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            wdog     <= '0;
            video_ok <= 1'b0;
        end else begin
            if (vs_rise)            wdog <= '0;
            else if (wdog != WD_MAX) wdog <= wdog + WD_W'(1);

            if (vs_rise)             video_ok <= (lcnt >= LC_MIN);
            else if (wdog == WD_MAX) video_ok <= 1'b0;
        end
    end

    assign bus.scnl_sw    = scnl_q;
    assign bus.pending    = pending_w;
    assign bus.applied    = applied_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.video_ok   = video_ok;
    assign bus.line_count = line_count_q;
endmodule

// File: tb/tb_scanlines_ctrl.sv
`timescale 1ns/1ps
// Bench for scanlines_ctrl: directed scenarios plus randomized requests and
// frame shapes, checked against a frame-level model of the sequencer.
module tb_scanlines_ctrl;
    localparam int WDOG  = 5000;
    localparam int MINL  = 16;
    localparam int LCW   = 10;
    localparam int LCMAX = (1 << LCW) - 1;

    logic clk_vid = 1'b0;
    logic reset   = 1'b1;

    scanlines_ctrl_if #(.LC_W(LCW)) bus ();

    scanlines_ctrl #(
        .WDOG_CYCLES(WDOG),
        .MIN_LINES  (MINL),
        .LC_W       (LCW)
    ) dut (
        .clk_vid(clk_vid),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_vid = ~clk_vid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int vs_cyc   = 0;

    logic [3:0] order [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd12, 4'd5, 4'd10, 4'd15};
    logic [3:0] bad   [6]  = '{4'd6, 4'd7, 4'd9, 4'd11, 4'd13, 4'd14};

    // Model state: what the sequencer should hold at frame granularity.
    logic [3:0] m_active, m_req;
    bit         m_pending, m_vok;
    int         m_lcnt, m_line_count;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1);
    end

    function automatic bit is_valid(input logic [3:0] c);
        for (int i = 0; i < 10; i++) if (order[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] next_of(input logic [3:0] c);
        for (int i = 0; i < 10; i++) if (order[i] == c) return order[(i + 1) % 10];
        return 4'd0;
    endfunction

    task automatic tick();
        @(negedge clk_vid);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_active = 4'd0; m_req = 4'd0; m_pending = 1'b0; m_vok = 1'b0;
        m_lcnt = 0; m_line_count = 0;
    endtask

    // n lines of 12 clocks: DE for 6 clocks (if the line is active), hsync at clock 8.
    task automatic lines(input int n, input int nde);
        int bad_cnt; logic [3:0] exp_s, got_s;
        bad_cnt = 0; got_s = 4'd0;
        exp_s = m_vok ? m_active : 4'd0;
        for (int l = 0; l < n; l++) begin
            for (int c = 0; c < 12; c++) begin
                bus.core_de = (l < nde) && (c < 6);
                bus.core_hs = (c == 8);
                tick();
                if (bus.applied !== 1'b0 || bus.scnl_sw !== exp_s) begin
                    bad_cnt++;
                    got_s = bus.scnl_sw;
                end
            end
        end
        bus.core_de = 1'b0; bus.core_hs = 1'b0;
        m_lcnt = (m_lcnt + nde > LCMAX) ? LCMAX : m_lcnt + nde;
        n_checks++;
        if (bad_cnt !== 0) begin
            n_fail++;
            $display("FAIL lines_steady: %0d bad cycles, last scnl_sw=%0d expected %0d", bad_cnt, got_s, exp_s);
        end
    endtask

    // Cycle after a request capture: applies at once only without video.
    task automatic settle_request();
        bit exp_apply;
        exp_apply = m_pending && !m_vok;
        if (exp_apply) begin m_active = m_req; m_pending = 1'b0; end
        tick();
        n_checks++;
        if (bus.applied !== exp_apply) begin n_fail++; $display("FAIL settle_applied: got %0b expected %0b", bus.applied, exp_apply); end
        n_checks++;
        if (bus.pending !== m_pending) begin n_fail++; $display("FAIL settle_pending: got %0b expected %0b", bus.pending, m_pending); end
        n_checks++;
        if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL settle_cfg_err: got %0b expected 0", bus.cfg_err); end
    endtask

    task automatic cfg_write(input logic [3:0] code);
        bit ok;
        ok = is_valid(code);
        bus.cfg_sw = code; bus.cfg_wr = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
        if (ok) begin m_req = code; m_pending = 1'b1; end
        n_checks++;
        if (bus.cfg_err !== !ok) begin n_fail++; $display("FAIL cfg_err: code %0d got %0b expected %0b", code, bus.cfg_err, !ok); end
        n_checks++;
        if (bus.pending !== m_pending) begin n_fail++; $display("FAIL cfg_pending: got %0b expected %0b", bus.pending, m_pending); end
        settle_request();
    endtask

    task automatic btn_press();
        logic [3:0] base;
        base = m_pending ? m_req : m_active;
        bus.btn_cycle = 1'b1;
        tick();
        bus.btn_cycle = 1'b0;
        m_req = next_of(base); m_pending = 1'b1;
        n_checks++;
        if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL btn_pending: got %0b expected 1", bus.pending); end
        settle_request();
    endtask

    // Frame start, optionally with a host write in the same cycle as the vs edge.
    task automatic vs_start(input bit with_req, input logic [3:0] code);
        logic [3:0] old_scnl, new_scnl;
        bit apply0, apply1, bad_code;
        old_scnl = m_vok ? m_active : 4'd0;
        apply0 = m_pending && m_vok;
        if (apply0) begin m_active = m_req; m_pending = 1'b0; end
        bad_code = with_req && !is_valid(code);
        if (with_req && !bad_code) begin m_req = code; m_pending = 1'b1; end
        m_line_count = m_lcnt; m_vok = (m_lcnt >= MINL); m_lcnt = 0;
        new_scnl = m_vok ? m_active : 4'd0;

        bus.core_vs = 1'b1; bus.cfg_wr = with_req; bus.cfg_sw = code;
        tick();
        vs_cyc = cyc;
        bus.cfg_wr = 1'b0;
        n_checks++;
        if (bus.applied !== apply0) begin n_fail++; $display("FAIL vs_applied: got %0b expected %0b", bus.applied, apply0); end
        n_checks++;
        if (bus.pending !== m_pending) begin n_fail++; $display("FAIL vs_pending: got %0b expected %0b", bus.pending, m_pending); end
        n_checks++;
        if (bus.video_ok !== m_vok) begin n_fail++; $display("FAIL vs_video_ok: got %0b expected %0b", bus.video_ok, m_vok); end
        n_checks++;
        if (bus.line_count !== LCW'(m_line_count)) begin n_fail++; $display("FAIL vs_line_count: got %0d expected %0d", bus.line_count, m_line_count); end
        n_checks++;
        if (bus.scnl_sw !== old_scnl) begin n_fail++; $display("FAIL vs_scnl_early: got %0d expected %0d", bus.scnl_sw, old_scnl); end
        n_checks++;
        if (bus.cfg_err !== bad_code) begin n_fail++; $display("FAIL vs_cfg_err: got %0b expected %0b", bus.cfg_err, bad_code); end

        apply1 = m_pending && !m_vok;
        if (apply1) begin m_active = m_req; m_pending = 1'b0; end
        tick();
        n_checks++;
        if (bus.scnl_sw !== new_scnl) begin n_fail++; $display("FAIL vs_scnl_2clk: got %0d expected %0d", bus.scnl_sw, new_scnl); end
        n_checks++;
        if (bus.applied !== apply1) begin n_fail++; $display("FAIL vs_applied_next: got %0b expected %0b", bus.applied, apply1); end
        n_checks++;
        if (bus.pending !== m_pending) begin n_fail++; $display("FAIL vs_pending_next: got %0b expected %0b", bus.pending, m_pending); end
        tick();
        bus.core_vs = 1'b0;
        tick();
    endtask

    task automatic check_zero_outputs(input bit tag_mid);
        n_checks++;
        if ({bus.scnl_sw, bus.pending, bus.applied, bus.cfg_err, bus.video_ok} !== 8'd0 || bus.line_count !== '0)
        begin
            n_fail++;
            $display("FAIL reset_outputs(mid=%0b): scnl=%0d pend=%0b appl=%0b err=%0b vok=%0b lc=%0d expected all 0",
                     tag_mid, bus.scnl_sw, bus.pending, bus.applied, bus.cfg_err, bus.video_ok, bus.line_count);
        end
    endtask

    task automatic test_reset();
        bus.cfg_sw = 4'd0; bus.cfg_wr = 1'b0; bus.btn_cycle = 1'b0;
        bus.core_hs = 1'b0; bus.core_vs = 1'b0; bus.core_de = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check_zero_outputs(1'b0);
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_frames();
        vs_start(1'b0, 4'd0);
        lines(240, 240);
        vs_start(1'b0, 4'd0);
    endtask

    task automatic test_host_write();
        lines(120, 120);
        cfg_write(4'd10);
        lines(120, 120);
        vs_start(1'b0, 4'd0);
    endtask

    task automatic test_invalid_code();
        lines(60, 60);
        cfg_write(4'd6);
        lines(180, 180);
        vs_start(1'b0, 4'd0);
    endtask

    task automatic test_button();
        lines(40, 40);
        cfg_write(4'd12);
        lines(200, 200);
        vs_start(1'b0, 4'd0);
        lines(80, 80);
        repeat (3) btn_press();
        lines(160, 160);
        vs_start(1'b0, 4'd0);
        lines(80, 80);
        bus.btn_cycle = 1'b1; bus.cfg_wr = 1'b1; bus.cfg_sw = 4'd3;
        tick();
        bus.btn_cycle = 1'b0; bus.cfg_wr = 1'b0;
        m_req = 4'd3; m_pending = 1'b1;
        n_checks++;
        if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL btn_vs_cfg_pending: got %0b expected 1", bus.pending); end
        settle_request();
        lines(160, 160);
        vs_start(1'b0, 4'd0);
    endtask

    task automatic test_watchdog();
        int elapsed;
        while (bus.video_ok === 1'b1 && (cyc - vs_cyc) < WDOG + 1000) tick();
        elapsed = cyc - vs_cyc;
        m_vok = 1'b0;
        n_checks++;
        if (elapsed !== WDOG + 1) begin n_fail++; $display("FAIL wdog_drop_time: got %0d cycles expected %0d", elapsed, WDOG + 1); end
        tick();
        n_checks++;
        if (bus.scnl_sw !== 4'd0) begin n_fail++; $display("FAIL wdog_scnl: got %0d expected 0", bus.scnl_sw); end
        cfg_write(4'd2);
        tick();
        n_checks++;
        if (bus.scnl_sw !== 4'd0) begin n_fail++; $display("FAIL wdog_bypass: got %0d expected 0", bus.scnl_sw); end
        vs_start(1'b0, 4'd0);
        lines(240, 240);
        vs_start(1'b0, 4'd0);
    endtask

    task automatic test_low_de_and_reset();
        lines(240, 8);
        vs_start(1'b0, 4'd0);
        lines(240, 240);
        vs_start(1'b0, 4'd0);
        lines(50, 50);
        cfg_write(4'd10);
        reset = 1'b1;
        #1;
        check_zero_outputs(1'b1);
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        vs_start(1'b0, 4'd0);
        lines(240, 240);
        vs_start(1'b0, 4'd0);
    endtask

    task automatic test_same_cycle();
        lines(100, 100);
        cfg_write(4'd4);
        lines(140, 140);
        vs_start(1'b1, 4'd8);
        lines(240, 240);
        vs_start(1'b0, 4'd0);
        lines(240, 240);
        vs_start(1'b1, 4'd1);
        lines(240, 240);
        vs_start(1'b0, 4'd0);
    endtask

    task automatic test_random();
        int kind;
        for (int r = 0; r < 10; r++) begin
            kind = $urandom_range(0, 3);
            lines(10, $urandom_range(0, 10));
            case (kind)
                0:       cfg_write(order[$urandom_range(0, 9)]);
                1:       cfg_write(bad[$urandom_range(0, 5)]);
                2:       repeat ($urandom_range(1, 3)) btn_press();
                default: ;
            endcase
            lines(10, $urandom_range(0, 10));
            if (kind == 3) vs_start(1'b1, order[$urandom_range(0, 9)]);
            else           vs_start(1'b0, 4'd0);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_host_write();
        test_invalid_code();
        test_button();
        test_watchdog();
        test_low_de_and_reset();
        test_same_cycle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
